// File: rtl/nios_pio_gen2.sv
// Avalon-MM parallel I/O: WIDTH-bit output register with set/clear aliases,
// synchronised input port with per-bit edge capture and maskable level interrupt.
module nios_pio_gen2 #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] s_last;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_val;
    logic [CNT_W-1:0] warm_cnt;
    logic             wr_en;

    function automatic logic [WIDTH-1:0] edge_detect(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] old);
        case (EDGE_TYPE)
            1:       return ~cur & old;
            2:       return cur ^ old;
            default: return cur & ~old;
        endcase
    endfunction

    assign wr_en   = chipselect && !write_n;
    assign wd      = writedata[WIDTH-1:0];
    assign s_last  = sync_p[SYNC_STAGES-1];
    // Detection stays off until the synchroniser and prev hold real samples.
    assign det     = (warm_cnt == WARM_DONE) ? edge_detect(s_last, prev) : '0;
    assign cap_clr = (wr_en && address == 3'd3) ? wd : '0;

    generate
        if (WIDTH < 32) begin : g_wd_upper
            logic unused_wd_upper;
            assign unused_wd_upper = ^writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            prev     <= '0;
            warm_cnt <= '0;
        end else begin
            sync_p[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            prev <= s_last;
            if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE[WIDTH-1:0];
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_en) begin
                case (address)
                    3'd0:    data_out <= wd;
                    3'd2:    irq_mask <= wd;
                    3'd4:    data_out <= data_out | wd;
                    3'd5:    data_out <= data_out & ~wd;
                    default: ;
                endcase
            end
            // A new edge wins over a simultaneous write-one-to-clear.
            edge_cap <= (edge_cap & ~cap_clr) | det;
        end
    end

    always_comb begin
        rd_val = '0;
        case (address)
            3'd0:    rd_val = data_out;
            3'd1:    rd_val = s_last;
            3'd2:    rd_val = irq_mask;
            3'd3:    rd_val = edge_cap;
            default: rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);
    assign out_port = data_out;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_pio_gen2.sv
// Directed bench for nios_pio_gen2: a rising-edge instance (reset value A5)
// and a falling-edge instance share the bus; expectations go through a queue.
module tb_nios_pio_gen2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata0, readdata1;
    logic [7:0]  in_port0, in_port1;
    logic [7:0]  out_port0, out_port1;
    logic        irq0, irq1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    nios_pio_gen2 #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata0),
        .in_port(in_port0), .out_port(out_port0), .irq(irq0)
    );

    nios_pio_gen2 #(.WIDTH(8), .RESET_VALUE(32'h0), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata1),
        .in_port(in_port1), .out_port(out_port1), .irq(irq1)
    );

    task automatic expect_val(input string tag, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic check(input logic [31:0] obs);
        item_t it;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty: got %h required an expectation", obs);
        end else begin
            it = sb.pop_front();
            n_vec++;
            assert (obs === it.exp) else begin
                n_err++;
                $error("FAIL %s: got %h required %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd0(input logic [2:0] a, input string tag, input logic [31:0] exp);
        expect_val(tag, exp);
        address = a;
        #1;
        check(readdata0);
    endtask

    task automatic rd1(input logic [2:0] a, input string tag, input logic [31:0] exp);
        expect_val(tag, exp);
        address = a;
        #1;
        check(readdata1);
    endtask

    initial begin
        reset      = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port0   = 8'h00;
        in_port1   = 8'hFF;
        #1 reset = 1'b1;
        #1;
        expect_val("reset_out_port", 32'hA5);
        check(32'(out_port0));
        expect_val("reset_irq", 32'h0);
        check(32'(irq0));
        rd0(3'd0, "reset_rd_data_out", 32'h0000_00A5);
        rd0(3'd3, "reset_rd_edge_cap", 32'h0);

        tick(3);
        reset = 1'b0;
        tick(1);
        rd1(3'd3, "warmup_edge_cap_early", 32'h0);
        tick(5);
        rd1(3'd3, "warmup_edge_cap_late", 32'h0);
        rd1(3'd1, "static_data_in", 32'h0000_00FF);

        // Full write, then set/clear aliases
        expect_val("wr0_out_port", 32'h3C);
        wr(3'd0, 32'h0000_FF3C);
        check(32'(out_port0));
        rd0(3'd0, "wr0_rd_upper_discarded", 32'h0000_003C);
        expect_val("outset_out_port", 32'h3F);
        wr(3'd4, 32'h03);
        check(32'(out_port0));
        rd0(3'd4, "outset_reads_zero", 32'h0);
        expect_val("outclr_out_port", 32'h0F);
        wr(3'd5, 32'h30);
        check(32'(out_port0));
        rd0(3'd5, "outclr_reads_zero", 32'h0);
        expect_val("reserved_write_ignored", 32'h0F);
        wr(3'd6, 32'hFF);
        check(32'(out_port0));
        rd0(3'd7, "reserved_reads_zero", 32'h0);

        // Rising edge on dut0 bit0: latency, capture, mask, W1C
        in_port0 = 8'h01;
        tick(1);
        rd0(3'd1, "data_in_after_1", 32'h00);
        tick(1);
        rd0(3'd1, "data_in_after_2", 32'h01);
        rd0(3'd3, "edge_cap_after_2", 32'h00);
        tick(1);
        rd0(3'd3, "edge_cap_after_3", 32'h01);
        expect_val("irq_masked", 32'h0);
        check(32'(irq0));
        expect_val("irq_after_mask", 32'h1);
        wr(3'd2, 32'h01);
        check(32'(irq0));
        expect_val("data_in_write_ignored", 32'h01);
        wr(3'd1, 32'hFE);
        address = 3'd1;
        #1;
        check(readdata0);
        expect_val("w1c_zero_no_effect", 32'h01);
        wr(3'd3, 32'h00);
        address = 3'd3;
        #1;
        check(readdata0);
        expect_val("irq_mask_cleared", 32'h0);
        wr(3'd2, 32'h00);
        check(32'(irq0));
        rd0(3'd3, "mask_keeps_edge_cap", 32'h01);
        wr(3'd2, 32'h01);
        expect_val("irq_after_w1c", 32'h0);
        wr(3'd3, 32'h01);
        check(32'(irq0));
        rd0(3'd3, "edge_cap_after_w1c", 32'h00);

        // Falling edge on dut1 bit7 after a static-high reset release
        in_port1 = 8'h7F;
        tick(2);
        rd1(3'd3, "fall_edge_cap_after_2", 32'h00);
        tick(1);
        rd1(3'd3, "fall_edge_cap_after_3", 32'h80);

        // Simultaneous W1C and new rising edge on dut0 bit0
        in_port0 = 8'h00;
        tick(4);
        in_port0 = 8'h01;
        tick(3);
        expect_val("irq_before_collision", 32'h1);
        check(32'(irq0));
        in_port0 = 8'h00;
        tick(4);
        in_port0 = 8'h01;
        tick(2);
        wr(3'd3, 32'h01);
        rd0(3'd3, "collision_set_wins", 32'h01);
        expect_val("collision_irq", 32'h1);
        check(32'(irq0));

        // Asynchronous reset while irq is pending
        expect_val("pre_reset_out_port", 32'h55);
        wr(3'd0, 32'h55);
        check(32'(out_port0));
        #1 reset = 1'b1;
        #1;
        expect_val("async_reset_irq", 32'h0);
        check(32'(irq0));
        expect_val("async_reset_out_port", 32'hA5);
        check(32'(out_port0));
        rd0(3'd3, "async_reset_edge_cap", 32'h0);
        rd0(3'd2, "async_reset_mask", 32'h0);
        tick(2);
        reset = 1'b0;
        tick(2);

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
